// File: rtl/mc_fifo_pkg.sv
// Shared constants, fixed-point word type and sizing helper for mc_fifo.
package mc_fifo_pkg;

  localparam int IL_DEF = 8;
  localparam int FL_DEF = 12;

  // Fixed-point operand word, IL integer bits above FL fraction bits.
  typedef logic [IL_DEF+FL_DEF-1:0] fx_t;

  // Occupancy counter width able to hold 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ch_ctrl.sv
// Per-channel FIFO bookkeeping: read/write pointers, occupancy count and
// the status flags decoded from that count.
module fifo_ch_ctrl
  import mc_fifo_pkg::*;
#(
  parameter int DEPTH     = 32,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4,
  parameter int PTR_W     = $clog2(DEPTH),
  parameter int CNT_W     = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_acc,
  input  logic             rd_acc,
  output logic [PTR_W-1:0] wr_ptr,
  output logic [PTR_W-1:0] rd_ptr,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full
);

  // Advance pointers on accepted strobes; DEPTH is a power of two so the
  // natural pointer overflow gives the modulo wrap without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Flags are pure decodes of the registered count.
  assign empty        = (count == '0);
  assign full         = (count == CNT_W'(DEPTH));
  assign almost_empty = (count <= CNT_W'(AE_THRESH));
  assign almost_full  = (count >= CNT_W'(AF_THRESH));

endmodule

// File: rtl/mc_fifo.sv
// Multi-channel single-clock FIFO for fixed-point operands. NUM_CH queues
// share one storage array; each channel is steered by wr_ch / rd_ch.
// Optional sticky overflow/underflow flags are built when MC_FIFO_ERR_EN
// is defined.
module mc_fifo
  import mc_fifo_pkg::*;
#(
  parameter int IL        = IL_DEF,
  parameter int FL        = FL_DEF,
  parameter int DATA_W    = IL + FL,
  parameter int DEPTH     = 32,
  parameter int NUM_CH    = 4,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int CNT_W     = cnt_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [CH_W-1:0]         wr_ch,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    rd_en,
  input  logic [CH_W-1:0]         rd_ch,
  output logic [DATA_W-1:0]       data_out,
  output logic                    data_valid,
  output logic [NUM_CH-1:0]       empty,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       almost_empty,
  output logic [NUM_CH-1:0]       almost_full,
  output logic [NUM_CH*CNT_W-1:0] count
`ifdef MC_FIFO_ERR_EN
  ,
  output logic [NUM_CH-1:0]       ovf,
  output logic [NUM_CH-1:0]       udf
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]  wr_ptr [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr [NUM_CH];
  logic [NUM_CH-1:0] wr_sel, rd_sel, wr_acc, rd_acc;
  logic [DATA_W-1:0] mem [NUM_CH][DEPTH];
  logic [DATA_W-1:0] rd_word;

  // Channel decode and accept: an out-of-range select matches no channel,
  // and flags come from pre-edge counts so full/empty block same-cycle
  // pass-through.
  always_comb begin
    wr_sel  = '0;
    rd_sel  = '0;
    wr_acc  = '0;
    rd_acc  = '0;
    rd_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_sel[c] = (wr_ch == CH_W'(c));
      rd_sel[c] = (rd_ch == CH_W'(c));
      wr_acc[c] = wr_en & wr_sel[c] & ~full[c];
      rd_acc[c] = rd_en & rd_sel[c] & ~empty[c];
      if (rd_sel[c]) rd_word = mem[c][rd_ptr[c]];
    end
  end

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr_acc[c]) mem[c][wr_ptr[c]] <= data_in;
    end
  end

  // Registered read port: data_out holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= |rd_acc;
      if (|rd_acc) data_out <= rd_word;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W-1:0] ch_count;

    fifo_ch_ctrl #(
      .DEPTH     (DEPTH),
      .AF_THRESH (AF_THRESH),
      .AE_THRESH (AE_THRESH),
      .PTR_W     (PTR_W),
      .CNT_W     (CNT_W)
    ) u_ctrl (
      .clk          (clk),
      .reset        (reset),
      .wr_acc       (wr_acc[g]),
      .rd_acc       (rd_acc[g]),
      .wr_ptr       (wr_ptr[g]),
      .rd_ptr       (rd_ptr[g]),
      .count        (ch_count),
      .empty        (empty[g]),
      .full         (full[g]),
      .almost_empty (almost_empty[g]),
      .almost_full  (almost_full[g])
    );

    assign count[g*CNT_W +: CNT_W] = ch_count;
  end

`ifdef MC_FIFO_ERR_EN
  // Sticky error capture: requests rejected because of full/empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf <= '0;
      udf <= '0;
    end else begin
      ovf <= ovf | ({NUM_CH{wr_en}} & wr_sel & full);
      udf <= udf | ({NUM_CH{rd_en}} & rd_sel & empty);
    end
  end
`else
  // Without error tracking, rejected requests leave no trace.
`endif

endmodule

// File: tb/tb_mc_fifo.sv
// Self-checking bench for mc_fifo: reset checks, directed fill/drain,
// wrap, interleave and mid-operation reset sequences, a vector table,
// and randomized traffic compared against a queue-based reference model.
module tb_mc_fifo;
  import mc_fifo_pkg::*;

  localparam int NUM_CH = 4;
  localparam int DEPTH  = 32;
  localparam int CNT_W  = 6;
  localparam int DATA_W = 20;
  localparam int CH_W   = 2;
  localparam int AF     = 28;
  localparam int AE     = 4;

  logic                    clk, reset;
  logic                    wr_en, rd_en;
  logic [CH_W-1:0]         wr_ch, rd_ch;
  logic [DATA_W-1:0]       data_in, data_out;
  logic                    data_valid;
  logic [NUM_CH-1:0]       empty, full, almost_empty, almost_full;
  logic [NUM_CH*CNT_W-1:0] count;
`ifdef MC_FIFO_ERR_EN
  logic [NUM_CH-1:0]       ovf, udf;
`endif

  mc_fifo #(.DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .rd_ch        (rd_ch),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count)
`ifdef MC_FIFO_ERR_EN
    ,
    .ovf          (ovf),
    .udf          (udf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one queue per channel plus output/error state.
  fx_t               q [NUM_CH][$];
  logic [DATA_W-1:0] m_dout = '0;
  logic              m_dv   = 1'b0;
  logic [NUM_CH-1:0] m_ovf  = '0;
  logic [NUM_CH-1:0] m_udf  = '0;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic              we;
    logic [CH_W-1:0]   wc;
    logic [DATA_W-1:0] din;
    logic              re;
    logic [CH_W-1:0]   rc;
    logic              edv;
    logic [DATA_W-1:0] edout;
    int                ech;
    int                ecnt;
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int c);
    return 32'(count[c*CNT_W +: CNT_W]);
  endfunction

  task automatic model_update();
    int  wc, rc;
    bit  wok, rok;
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) q[c].delete();
      m_dout = '0;
      m_dv   = 1'b0;
      m_ovf  = '0;
      m_udf  = '0;
    end else begin
      wc  = int'(wr_ch);
      rc  = int'(rd_ch);
      wok = wr_en && wc < NUM_CH && q[wc].size() < DEPTH;
      rok = rd_en && rc < NUM_CH && q[rc].size() > 0;
      if (wr_en && wc < NUM_CH && q[wc].size() == DEPTH) m_ovf[wc] = 1'b1;
      if (rd_en && rc < NUM_CH && q[rc].size() == 0) m_udf[rc] = 1'b1;
      m_dv = rok;
      if (rok) m_dout = q[rc].pop_front();
      if (wok) q[wc].push_back(data_in);
    end
  endtask

  task automatic check_model();
    int sz;
    for (int c = 0; c < NUM_CH; c++) begin
      sz = q[c].size();
      chk($sformatf("model_count[%0d]", c), cnt_of(c), 32'(sz));
      chk($sformatf("model_empty[%0d]", c), 32'(empty[c]), 32'(sz == 0));
      chk($sformatf("model_full[%0d]", c), 32'(full[c]), 32'(sz == DEPTH));
      chk($sformatf("model_ae[%0d]", c), 32'(almost_empty[c]), 32'(sz <= AE));
      chk($sformatf("model_af[%0d]", c), 32'(almost_full[c]), 32'(sz >= AF));
    end
    chk("model_data_valid", 32'(data_valid), 32'(m_dv));
    chk("model_data_out", 32'(data_out), 32'(m_dout));
`ifdef MC_FIFO_ERR_EN
    chk("model_ovf", 32'(ovf), 32'(m_ovf));
    chk("model_udf", 32'(udf), 32'(m_udf));
`endif
  endtask

  // One clock: model sees pre-edge inputs, outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_model();
  endtask

  task automatic idle();
    wr_en = 1'b0; rd_en = 1'b0; wr_ch = '0; rd_ch = '0; data_in = '0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset then idle
    chk("rst_empty", 32'(empty), 32'hF);
    chk("rst_ae", 32'(almost_empty), 32'hF);
    chk("rst_full", 32'(full), 32'h0);
    chk("rst_af", 32'(almost_full), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_dv", 32'(data_valid), 32'h0);
    chk("rst_dout", 32'(data_out), 32'h0);

    // Fill ch2 to full, then one dropped write
    for (int i = 0; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_ch = 2; data_in = DATA_W'(i + 1);
      step();
      chk("fill_af2", 32'(almost_full[2]), 32'((i + 1) >= 28));
    end
    data_in = 20'h00021;
    step();
    chk("fill_full2", 32'(full[2]), 32'h1);
    chk("fill_count2", cnt_of(2), 32'd32);
`ifdef MC_FIFO_ERR_EN
    chk("fill_ovf2", 32'(ovf[2]), 32'h1);
`endif

    // Drain ch2 back to back
    idle();
    rd_en = 1'b1; rd_ch = 2;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk("drain_dv", 32'(data_valid), 32'h1);
      chk("drain_dout", 32'(data_out), 32'(i + 1));
    end
    chk("drain_empty2", 32'(empty[2]), 32'h1);
    step();
    chk("extra_rd_dv", 32'(data_valid), 32'h0);
    chk("extra_rd_dout", 32'(data_out), 32'h00020);
`ifdef MC_FIFO_ERR_EN
    chk("extra_rd_udf2", 32'(udf[2]), 32'h1);
`endif

    // ch1 holding 5 words, 40 cycles of simultaneous read+write across wrap
    idle();
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_ch = 1; data_in = DATA_W'(32'h100 + i);
      step();
    end
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1; wr_ch = 1; data_in = DATA_W'(32'h105 + i);
      rd_en = 1'b1; rd_ch = 1;
      step();
      chk("rw_count1", cnt_of(1), 32'd5);
      chk("rw_dout", 32'(data_out), 32'h100 + i);
    end
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;

    // Vector table: interleaved channels and no fall-through
    vt[0] = '{1'b1, 2'd0, 20'hAAAAA, 1'b1, 2'd3, 1'b0, 20'h00000, 0, 1};
    vt[1] = '{1'b0, 2'd0, 20'h00000, 1'b1, 2'd0, 1'b1, 20'hAAAAA, 0, 0};
    vt[2] = '{1'b0, 2'd0, 20'h00000, 1'b0, 2'd0, 1'b0, 20'hAAAAA, 0, 0};
    vt[3] = '{1'b1, 2'd1, 20'h12345, 1'b1, 2'd1, 1'b0, 20'hAAAAA, 1, 1};
    vt[4] = '{1'b1, 2'd1, 20'h00777, 1'b1, 2'd1, 1'b1, 20'h12345, 1, 1};
    vt[5] = '{1'b0, 2'd0, 20'h00000, 1'b1, 2'd1, 1'b1, 20'h00777, 1, 0};
    for (int v = 0; v < 6; v++) begin
      wr_en = vt[v].we; wr_ch = vt[v].wc; data_in = vt[v].din;
      rd_en = vt[v].re; rd_ch = vt[v].rc;
      step();
      chk($sformatf("vec%0d_dv", v), 32'(data_valid), 32'(vt[v].edv));
      chk($sformatf("vec%0d_dout", v), 32'(data_out), 32'(vt[v].edout));
      chk($sformatf("vec%0d_count", v), cnt_of(vt[v].ech), 32'(vt[v].ecnt));
    end

    // Reset while ch0 holds 10 words
    idle();
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_ch = 0; data_in = DATA_W'(32'h300 + i);
      step();
    end
    chk("pre_rst_count0", cnt_of(0), 32'd10);
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_count0", cnt_of(0), 32'd0);
    chk("mid_rst_empty0", 32'(empty[0]), 32'h1);
    rd_en = 1'b1; rd_ch = 0;
    step();
    chk("post_rst_rd_dv", 32'(data_valid), 32'h0);
    chk("post_rst_count0", cnt_of(0), 32'd0);

    // Randomized traffic against the reference model
    idle();
    for (int i = 0; i < 3000; i++) begin
      int blk, wp;
      blk = i / 250;
      wp  = (blk % 2 == 0) ? 80 : 30;
      reset   = ($urandom_range(0, 299) == 0);
      wr_en   = ($urandom_range(0, 99) < wp);
      rd_en   = ($urandom_range(0, 99) < 100 - wp + 10);
      wr_ch   = (blk % 3 == 0) ? CH_W'(0) : CH_W'($urandom_range(0, NUM_CH - 1));
      rd_ch   = (blk % 3 == 0) ? CH_W'(0) : CH_W'($urandom_range(0, NUM_CH - 1));
      data_in = DATA_W'($urandom);
      step();
    end
    reset = 1'b0;
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
